musb_pipe_register: RTL and testbench
=====================================

MUSB_PIPE_REGISTER -- requirements
Module: musb_pipe_register

Interface
REQ-001 SHALL have parameter DATA_W, default 64, meaning width of the payload carried without kill semantics (results, addresses, PCs).
REQ-002 SHALL have parameter CTRL_W, default 8, meaning width of the control field (write enables, trap, exception-source bits).
REQ-003 SHALL have parameter KILL_MASK, default {CTRL_W{1'b1}}, meaning the control bits forced to 0 whenever the output holds a bubble.
REQ-004 SHALL have parameter SKID, default 1, meaning 1 = two-entry skid buffer with registered up_ready, 0 = single register with combinational up_ready.
REQ-005 SHALL have these ports (name, direction, width, meaning):
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset (asserted at 0).
- up_valid  in  1  upstream beat present.
- up_ready  out  1  stage accepts a beat this cycle.
- up_flush  in  1  discard the offered upstream beat.
- up_data  in  DATA_W  upstream payload.
- up_ctrl  in  CTRL_W  upstream control.
- dn_valid  out  1  output beat present.
- dn_ready  in  1  downstream consumes the beat.
- dn_flush  in  1  kill all stored beats.
- dn_data  out  DATA_W  output payload.
- dn_ctrl  out  CTRL_W  output control, masked per REQ-013.
- occupancy  out  2  stored beat count, 0..2.

Function
REQ-006 SHALL hold a main entry M (data, ctrl, valid) and, when SKID=1, a skid entry S; dn_valid, dn_data and dn_ctrl SHALL always come from M.
REQ-007 SHALL accept a beat when up_valid & up_ready & ~up_flush & ~dn_flush; flushed beats are dropped and not counted.
REQ-008 SHALL have a latency of 1 cycle: a beat accepted into an empty M appears on dn_valid at the next edge; sustained throughput SHALL be 1 beat/cycle with dn_ready held at 1.
REQ-009 SHALL drive up_ready = ~S.valid (registered) when SKID=1, and up_ready = ~M.valid | dn_ready when SKID=0; up_ready SHALL be 0 while rst is asserted.
REQ-010 SHALL, when SKID=1, update per edge:
- M empty + accept: M <= beat.
- M full, dn_ready=1, S empty: M <= beat if accepted, else M.valid <= 0.
- M full, dn_ready=0 + accept: S <= beat; M unchanged.
- S full, dn_ready=1: M <= S, S.valid <= 0; no accept is possible.
- M full, dn_ready=0, no accept: hold.
REQ-011 SHALL preserve strict FIFO order with no beat duplicated or lost.
REQ-012 SHALL, on dn_flush=1 at an edge, clear M.valid and S.valid and accept nothing; dn_flush SHALL take priority over every other event at that edge.
REQ-013 SHALL drive dn_ctrl = M.ctrl when dn_valid=1 and M.ctrl & ~KILL_MASK when dn_valid=0, so a stalled or flushed stage never presents a live write enable.
REQ-014 SHALL retain dn_data unchanged on bubble and flush (no data clearing).
REQ-015 SHALL drive occupancy = M.valid + S.valid, with S.valid counted as 0 when SKID=0.
REQ-016 SHALL never set S.valid=1 while M.valid=0.

Reset
REQ-017 SHALL, while rst=0, asynchronously clear M and S (valid, data, ctrl) to 0, forcing dn_valid=0, dn_data=0, dn_ctrl=0, occupancy=0 and up_ready=0.
REQ-018 SHALL, at the first edge after rst rises, drive up_ready=1 and be ready to accept.
REQ-019 SHALL, on reset asserted mid-transfer, discard all stored beats; no beat accepted before reset appears after reset.

Verification
REQ-020 SHALL cover streaming: SKID=1, dn_ready=1, beats D0..D9 back-to-back -> dn_data D0..D9 one cycle later, occupancy 1, up_ready stays 1.
REQ-021 SHALL cover backpressure: dn_ready=0 for 3 cycles while offering A, B, C -> A in M, B in S, up_ready=0, C held by upstream; on dn_ready=1, outputs A, B, C in order.
REQ-022 SHALL cover bubble masking: KILL_MASK=8'h0F, M.ctrl=8'hFF consumed with no new beat -> dn_valid=0, dn_ctrl=8'hF0.
REQ-023 SHALL cover flush collision: occupancy 2 with up_valid=1, dn_flush=1 for one edge -> occupancy 0, dn_valid=0, offered beat lost; separately up_flush=1 with empty stage -> occupancy stays 0.
REQ-024 SHALL cover SKID=0: M full, dn_ready=0 -> up_ready=0 in the same cycle; dn_ready=1 with up_valid=1 -> M replaced in one edge.
REQ-025 SHALL cover async reset: rst driven to 0 between edges with occupancy 2 -> dn_valid=0, occupancy 0 immediately, with no clock edge required.

Source files
------------

// File: rtl/musb_pipe_register.sv
// Pipeline stage register with valid/ready handshake, optional two-entry skid buffer,
// flush from either side and kill-masking of control bits on bubbles.
module musb_pipe_register #(
  parameter int                DATA_W    = 64,
  parameter int                CTRL_W    = 8,
  parameter logic [CTRL_W-1:0] KILL_MASK = {CTRL_W{1'b1}},
  parameter bit                SKID      = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              up_valid,
  output logic              up_ready,
  input  logic              up_flush,
  input  logic [DATA_W-1:0] up_data,
  input  logic [CTRL_W-1:0] up_ctrl,
  output logic              dn_valid,
  input  logic              dn_ready,
  input  logic              dn_flush,
  output logic [DATA_W-1:0] dn_data,
  output logic [CTRL_W-1:0] dn_ctrl,
  output logic [1:0]        occupancy
);

  logic              r_mValid;
  logic [DATA_W-1:0] r_mData;
  logic [CTRL_W-1:0] r_mCtrl;
  logic              r_sValid;
  logic [DATA_W-1:0] r_sData;
  logic [CTRL_W-1:0] r_sCtrl;
  logic              r_live;

  logic w_upReady;
  logic w_accept;

  // r_live keeps up_ready low until the first edge after reset is released.
  assign w_upReady = r_live & ((SKID != 1'b0) ? ~r_sValid : (~r_mValid | dn_ready));
  assign w_accept  = up_valid & w_upReady & ~up_flush & ~dn_flush;

  // With SKID=0 the skid entry can never fill: a full, stalled M blocks acceptance.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mValid <= 1'b0;
      r_mData  <= '0;
      r_mCtrl  <= '0;
      r_sValid <= 1'b0;
      r_sData  <= '0;
      r_sCtrl  <= '0;
      r_live   <= 1'b0;
    end else begin
      r_live <= 1'b1;
      if (dn_flush) begin
        r_mValid <= 1'b0;
        r_sValid <= 1'b0;
      end else if (r_sValid) begin
        if (dn_ready) begin
          r_mData  <= r_sData;
          r_mCtrl  <= r_sCtrl;
          r_sValid <= 1'b0;
        end
      end else if (!r_mValid || dn_ready) begin
        r_mValid <= w_accept;
        if (w_accept) begin
          r_mData <= up_data;
          r_mCtrl <= up_ctrl;
        end
      end else if (w_accept) begin
        r_sValid <= 1'b1;
        r_sData  <= up_data;
        r_sCtrl  <= up_ctrl;
      end
    end
  end

  assign up_ready  = w_upReady;
  assign dn_valid  = r_mValid;
  assign dn_data   = r_mData;
  assign dn_ctrl   = r_mValid ? r_mCtrl : (r_mCtrl & ~KILL_MASK);
  assign occupancy = {1'b0, r_mValid} + {1'b0, r_sValid};

endmodule

// File: tb/tb_musb_pipe_register.sv
// Bench for musb_pipe_register: a skid instance and a single-register instance share
// stimulus and are each compared against a queue-based FIFO model every cycle.
module tb_musb_pipe_register;

  localparam logic [7:0] KM1 = 8'h0F;
  localparam logic [7:0] KM0 = 8'hFF;

  typedef struct packed {
    logic [63:0] d;
    logic [7:0]  c;
  } beat_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic upValid = 1'b0, upFlush = 1'b0, dnReady = 1'b0, dnFlush = 1'b0;
  logic [63:0] upData = '0;
  logic [7:0]  upCtrl = '0;

  logic        upReady1, dnValid1;
  logic [63:0] dnData1;
  logic [7:0]  dnCtrl1;
  logic [1:0]  occ1;
  logic        upReady0, dnValid0;
  logic [15:0] dnData0;
  logic [7:0]  dnCtrl0;
  logic [1:0]  occ0;

  int compared = 0;
  int mismatched = 0;

  beat_t q1[$];
  beat_t q0[$];
  beat_t held1 = '0;
  beat_t held0 = '0;
  bit    live = 1'b0;

  always #5 clk = ~clk;

  musb_pipe_register #(.DATA_W(64), .CTRL_W(8), .KILL_MASK(KM1), .SKID(1'b1)) dut1 (
    .clk(clk), .rst(rst), .up_valid(upValid), .up_ready(upReady1), .up_flush(upFlush),
    .up_data(upData), .up_ctrl(upCtrl), .dn_valid(dnValid1), .dn_ready(dnReady),
    .dn_flush(dnFlush), .dn_data(dnData1), .dn_ctrl(dnCtrl1), .occupancy(occ1)
  );

  musb_pipe_register #(.DATA_W(16), .CTRL_W(8), .KILL_MASK(KM0), .SKID(1'b0)) dut0 (
    .clk(clk), .rst(rst), .up_valid(upValid), .up_ready(upReady0), .up_flush(upFlush),
    .up_data(upData[15:0]), .up_ctrl(upCtrl), .dn_valid(dnValid0), .dn_ready(dnReady),
    .dn_flush(dnFlush), .dn_data(dnData0), .dn_ctrl(dnCtrl0), .occupancy(occ0)
  );

  // Single comparison point: counts every check and reports the ones that differ.
  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Expected outputs follow from the model: head of queue when non-empty, otherwise the
  // last beat that sat in the output register with its control bits killed.
  task automatic checkAll(input string phase);
    beat_t f1, f0;
    bit    v1, v0;
    v1 = (q1.size() != 0);
    v0 = (q0.size() != 0);
    f1 = held1;
    f0 = held0;
    if (v1) f1 = q1[0];
    if (v0) f0 = q0[0];
    checkOutput({phase, ":dn_valid1"}, 64'(dnValid1), 64'(v1));
    checkOutput({phase, ":dn_data1"}, dnData1, f1.d);
    checkOutput({phase, ":dn_ctrl1"}, 64'(dnCtrl1), 64'(v1 ? f1.c : (f1.c & ~KM1)));
    checkOutput({phase, ":occ1"}, 64'(occ1), 64'(q1.size()));
    checkOutput({phase, ":up_ready1"}, 64'(upReady1), 64'(live && q1.size() < 2));
    checkOutput({phase, ":dn_valid0"}, 64'(dnValid0), 64'(v0));
    checkOutput({phase, ":dn_data0"}, 64'(dnData0), 64'(f0.d[15:0]));
    checkOutput({phase, ":dn_ctrl0"}, 64'(dnCtrl0), 64'(v0 ? f0.c : (f0.c & ~KM0)));
    checkOutput({phase, ":occ0"}, 64'(occ0), 64'(q0.size()));
    checkOutput({phase, ":up_ready0"}, 64'(upReady0), 64'(live && (q0.size() == 0 || dnReady)));
  endtask

  // Drive one cycle of inputs after a falling edge, check, then advance the model over the rising edge.
  task automatic applyStimulus(input string phase, input logic v, input logic f, input logic dr,
                               input logic df, input logic [63:0] d, input logic [7:0] c);
    bit acc1, acc0;
    beat_t b;
    upValid = v; upFlush = f; dnReady = dr; dnFlush = df; upData = d; upCtrl = c;
    #1;
    checkAll(phase);
    b.d  = d;
    b.c  = c;
    acc1 = v && !f && !df && live && (q1.size() < 2);
    acc0 = v && !f && !df && live && (q0.size() == 0 || dr);
    @(posedge clk);
    if (rst) begin
      if (df) begin
        q1.delete();
        q0.delete();
      end else begin
        if (dr && q1.size() != 0) void'(q1.pop_front());
        if (dr && q0.size() != 0) void'(q0.pop_front());
        if (acc1) q1.push_back(b);
        if (acc0) q0.push_back(b);
      end
      live = 1'b1;
      if (q1.size() != 0) held1 = q1[0];
      if (q0.size() != 0) held0 = q0[0];
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus("idle", 1'b0, 1'b0, 1'b1, 1'b0, 64'h0, 8'h0);
  endtask

  initial begin
    $display("[TB] start");
    #2;
    checkAll("reset");
    @(negedge clk);
    rst = 1'b1;
    idle(2);

    // Streaming: back-to-back beats with downstream always ready.
    for (int i = 0; i < 10; i++)
      applyStimulus("stream", 1'b1, 1'b0, 1'b1, 1'b0, 64'hD0 + 64'(i), 8'(8'h10 + i));
    checkOutput("stream_occ1", 64'(occ1), 64'd1);
    checkOutput("stream_last", dnData1, 64'hD9);
    idle(2);

    // Backpressure: A to M, B to skid, C held upstream, then drain in order.
    applyStimulus("bp", 1'b1, 1'b0, 1'b0, 1'b0, 64'hAAAA, 8'hA1);
    applyStimulus("bp", 1'b1, 1'b0, 1'b0, 1'b0, 64'hBBBB, 8'hB1);
    applyStimulus("bp", 1'b1, 1'b0, 1'b0, 1'b0, 64'hCCCC, 8'hC1);
    checkOutput("bp_head", dnData1, 64'hAAAA);
    checkOutput("bp_occ", 64'(occ1), 64'd2);
    checkOutput("bp_ready", 64'(upReady1), 64'd0);
    applyStimulus("bp", 1'b1, 1'b0, 1'b1, 1'b0, 64'hCCCC, 8'hC1);
    checkOutput("bp_second", dnData1, 64'hBBBB);
    applyStimulus("bp", 1'b1, 1'b0, 1'b1, 1'b0, 64'hCCCC, 8'hC1);
    checkOutput("bp_third", dnData1, 64'hCCCC);
    idle(3);

    // Bubble masking: ctrl FF consumed with nothing behind it.
    applyStimulus("bubble", 1'b1, 1'b0, 1'b1, 1'b0, 64'h2222, 8'hFF);
    applyStimulus("bubble", 1'b0, 1'b0, 1'b1, 1'b0, 64'h0, 8'h0);
    checkOutput("bubble_valid", 64'(dnValid1), 64'd0);
    checkOutput("bubble_ctrl1", 64'(dnCtrl1), 64'hF0);
    checkOutput("bubble_ctrl0", 64'(dnCtrl0), 64'h00);
    checkOutput("bubble_data", dnData1, 64'h2222);

    // Flush collision with a full stage, then an upstream flush into an empty stage.
    applyStimulus("flush", 1'b1, 1'b0, 1'b0, 1'b0, 64'h1111, 8'h01);
    applyStimulus("flush", 1'b1, 1'b0, 1'b0, 1'b0, 64'h1112, 8'h02);
    applyStimulus("flush", 1'b1, 1'b0, 1'b0, 1'b1, 64'h1113, 8'h03);
    checkOutput("flush_occ", 64'(occ1), 64'd0);
    checkOutput("flush_valid", 64'(dnValid1), 64'd0);
    applyStimulus("upflush", 1'b1, 1'b1, 1'b0, 1'b0, 64'h1114, 8'h04);
    checkOutput("upflush_occ", 64'(occ1), 64'd0);
    idle(1);

    // Single-register instance: stall blocks combinationally, ready replaces M in one edge.
    applyStimulus("noskid", 1'b1, 1'b0, 1'b0, 1'b0, 64'h5551, 8'h51);
    applyStimulus("noskid", 1'b1, 1'b0, 1'b0, 1'b0, 64'h5552, 8'h52);
    applyStimulus("noskid", 1'b1, 1'b0, 1'b1, 1'b0, 64'h5553, 8'h53);
    checkOutput("noskid_replace", 64'(dnData0), 64'h5553);
    idle(3);

    // Asynchronous reset between edges with a full skid stage.
    applyStimulus("areset", 1'b1, 1'b0, 1'b0, 1'b0, 64'h7771, 8'h71);
    applyStimulus("areset", 1'b1, 1'b0, 1'b0, 1'b0, 64'h7772, 8'h72);
    #2;
    rst = 1'b0;
    q1.delete(); q0.delete();
    held1 = '0; held0 = '0; live = 1'b0;
    #1;
    checkOutput("areset_valid", 64'(dnValid1), 64'd0);
    checkOutput("areset_occ", 64'(occ1), 64'd0);
    checkAll("areset");
    @(negedge clk);
    rst = 1'b1;
    idle(2);

    // Randomized traffic.
    for (int i = 0; i < 400; i++)
      applyStimulus("rand", ($urandom_range(0, 3) != 0), ($urandom_range(0, 9) == 0),
                    ($urandom_range(0, 2) != 0), ($urandom_range(0, 15) == 0),
                    {$urandom(), $urandom()}, 8'($urandom()));
    idle(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
